// File: rtl/apb4_clint_mh_if.sv
// APB4 bus bundle for the multi-hart CLINT; the testbench drives the master side.
interface apb4_clint_mh_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_clint_mh.sv
// Multi-hart CLINT: shared 64-bit mtime with prescaled RTC ticks, per-hart MSIP and MTIMECMP,
// zero-wait-state APB4 slave using the SiFive CLINT address layout.
module apb4_clint_mh #(
  parameter int unsigned NUM_HART    = 4,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                pclk,
  input  logic                presetn,
  apb4_clint_mh_if.slave      apb,
  input  logic                rtc_clk_i,
  output logic [NUM_HART-1:0] msip_irq_o,
  output logic [NUM_HART-1:0] mtip_irq_o
);

  localparam logic [31:0] CtrlAddr    = 32'h0000_BFF0;
  localparam logic [31:0] MtimeLoAddr = 32'h0000_BFF8;
  localparam logic [31:0] MtimeHiAddr = 32'h0000_BFFC;
  localparam logic [31:0] CmpBase     = 32'h0000_4000;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [31:0]           addr;
  logic [31:0]           msip_idx;
  logic [31:0]           cmp_idx;
  logic                  sel_msip, sel_cmp, sel_ctrl, sel_mtime, dec_err;
  logic                  access, wr_en;

  logic [NUM_HART-1:0]   msip_q, msip_d;
  logic [NUM_HART-1:0]   mtip_q;
  logic [63:0]           cmp_q [NUM_HART];
  logic [63:0]           cmp_d [NUM_HART];
  logic [63:0]           mtime_q, mtime_d;
  logic                  en_q, en_d;
  logic [7:0]            div_q, div_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  rtc_prev_q;
  logic                  tick_pulse;
  logic [31:0]           rdata;

  assign paddr    = apb.paddr;
  assign addr     = 32'(paddr);
  assign msip_idx = {2'b00, addr[31:2]};
  assign cmp_idx  = (addr - CmpBase) >> 3;

  always_comb begin
    sel_msip  = 1'b0;
    sel_cmp   = 1'b0;
    sel_ctrl  = 1'b0;
    sel_mtime = 1'b0;
    if (addr[31:16] == 16'h0) begin
      if (addr < CmpBase)                                 sel_msip  = (msip_idx < NUM_HART);
      else if (addr == CtrlAddr)                          sel_ctrl  = 1'b1;
      else if (addr == MtimeLoAddr || addr == MtimeHiAddr) sel_mtime = 1'b1;
      else if (addr < CtrlAddr)                           sel_cmp   = (cmp_idx < NUM_HART);
    end
  end

  assign dec_err = ~(sel_msip | sel_cmp | sel_ctrl | sel_mtime);
  assign access  = apb.psel & apb.penable;
  assign wr_en   = access & apb.pwrite & ~dec_err;

  always_comb begin
    rdata = 32'h0;
    if (access && !dec_err) begin
      if (sel_msip) begin
        for (int unsigned h = 0; h < NUM_HART; h++) begin
          if (msip_idx == h) rdata = {31'h0, msip_q[h]};
        end
      end else if (sel_cmp) begin
        for (int unsigned h = 0; h < NUM_HART; h++) begin
          if (cmp_idx == h) rdata = addr[2] ? cmp_q[h][63:32] : cmp_q[h][31:0];
        end
      end else if (sel_ctrl) begin
        rdata = {16'h0, div_q, 7'h0, en_q};
      end else begin
        rdata = addr[2] ? mtime_q[63:32] : mtime_q[31:0];
      end
    end
  end

  assign apb.prdata  = rdata;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = access & dec_err;

  assign tick_pulse = sync_q[SYNC_STAGES-1] & ~rtc_prev_q;

  always_comb begin
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    mtime_d = mtime_q;

    if (en_q && tick_pulse) begin
      if (cnt_q == div_q) begin
        cnt_d   = 8'h0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (wr_en && sel_ctrl) begin
      en_d  = apb.pwdata[0];
      div_d = apb.pwdata[15:8];
      cnt_d = 8'h0;
    end

    // A software write to mtime discards a coincident tick.
    if (wr_en && sel_mtime) begin
      mtime_d = mtime_q;
      if (addr[2]) mtime_d[63:32] = apb.pwdata;
      else         mtime_d[31:0]  = apb.pwdata;
    end

    for (int unsigned h = 0; h < NUM_HART; h++) begin
      if (wr_en && sel_msip && msip_idx == h) msip_d[h] = apb.pwdata[0];
      if (wr_en && sel_cmp && cmp_idx == h) begin
        if (addr[2]) cmp_d[h][63:32] = apb.pwdata;
        else         cmp_d[h][31:0]  = apb.pwdata;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      msip_q     <= '0;
      mtip_q     <= '0;
      mtime_q    <= 64'h0;
      en_q       <= 1'b1;
      div_q      <= 8'h0;
      cnt_q      <= 8'h0;
      sync_q     <= '0;
      rtc_prev_q <= 1'b0;
      for (int unsigned h = 0; h < NUM_HART; h++) cmp_q[h] <= '1;
    end else begin
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      en_q       <= en_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rtc_clk_i};
      rtc_prev_q <= sync_q[SYNC_STAGES-1];
      for (int unsigned h = 0; h < NUM_HART; h++) begin
        cmp_q[h]  <= cmp_d[h];
        mtip_q[h] <= (mtime_q >= cmp_q[h]);
      end
    end
  end

  assign msip_irq_o = msip_q;
  assign mtip_irq_o = mtip_q;

endmodule
